fetch_unit: RTL and testbench

// - Instruction fetch front end: generates PCs, issues reads to instruction memory, buffers returned words.
// - Presents {inst, pc} to the control unit decoder over a valid/ready handshake.
// - Producer side of the decoder's instruction input. Accepts PC redirects (branch/jump) from execute.

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: small circular FIFO of {pc, inst} entries with synchronous flush.
module fetch_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_s;
  logic             push_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? PW'(0) : (p + PW'(1));
  endfunction

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign pop_s  = pop && (count_r != CW'(0));
  assign push_s = push && ((count_r != CW'(DEPTH)) || pop_s);

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(0);
      end
    end else if (flush) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited memory reads,
// response buffering and redirect/flush handling towards the decoder.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_error
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = XLEN + INST_W;

  fetch_state_t    state_r, state_nxt_s;
  logic [31:0]     req_pc_r, req_pc_nxt_s;
  logic [31:0]     rsp_pc_r, rsp_pc_nxt_s;
  logic [31:0]     target_r, target_nxt_s;
  logic [CW-1:0]   outstanding_r, outstanding_nxt_s;
  logic [CW-1:0]   fifo_count_s;
  logic [FW-1:0]   fifo_rdata_s;
  logic            fifo_push_s;
  logic            pop_s;
  logic            credit_ok_s;
  logic            req_fire_s;
  logic            rsp_take_s;
  logic [31:0]     flush_tgt_s;

  // Words in flight plus words buffered may never exceed the buffer depth.
  assign pop_s          = inst_valid && inst_ready;
  assign credit_ok_s    = (32'(outstanding_r) + 32'(fifo_count_s) - 32'(pop_s)) < 32'(FIFO_DEPTH);
  assign imem_req_valid = (state_r == RUN) && !redirect_valid && credit_ok_s;
  assign imem_req_addr  = req_pc_r;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign rsp_take_s     = imem_rsp_valid && (outstanding_r != CW'(0));
  assign outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(rsp_take_s);
  assign flush_tgt_s    = redirect_valid ? redirect_pc : target_r;

  assign inst_valid  = (fifo_count_s != CW'(0)) && (state_r != ERROR);
  assign inst_pc     = fifo_rdata_s[FW-1:INST_W];
  assign inst_data   = fifo_rdata_s[INST_W-1:0];
  assign fetch_error = (state_r == ERROR);

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (redirect_valid),
    .push  (fifo_push_s),
    .pop   (pop_s),
    .wdata ({rsp_pc_r, imem_rsp_data}),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s)
  );

  // State, PC and credit registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= BOOT;
      req_pc_r      <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      target_r      <= RESET_PC;
      outstanding_r <= CW'(0);
    end else begin
      state_r       <= state_nxt_s;
      req_pc_r      <= req_pc_nxt_s;
      rsp_pc_r      <= rsp_pc_nxt_s;
      target_r      <= target_nxt_s;
      outstanding_r <= outstanding_nxt_s;
    end
  end

  // Next-state, PC update and buffer-write decisions; a misaligned redirect wins over everything.
  always_comb begin
    state_nxt_s  = state_r;
    req_pc_nxt_s = req_fire_s ? (req_pc_r + PC_STEP) : req_pc_r;
    rsp_pc_nxt_s = rsp_pc_r;
    target_nxt_s = target_r;
    fifo_push_s  = 1'b0;
    if (redirect_valid && pc_misaligned(redirect_pc)) begin
      state_nxt_s = ERROR;
    end else begin
      case (state_r)
        BOOT: begin
          state_nxt_s = RUN;
          if (redirect_valid) begin
            req_pc_nxt_s = redirect_pc;
            rsp_pc_nxt_s = redirect_pc;
          end else begin
            rsp_pc_nxt_s = rsp_pc_r;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            if (outstanding_nxt_s != CW'(0)) begin
              state_nxt_s  = FLUSH;
              target_nxt_s = redirect_pc;
            end else begin
              req_pc_nxt_s = redirect_pc;
              rsp_pc_nxt_s = redirect_pc;
            end
          end else if (rsp_take_s) begin
            fifo_push_s  = 1'b1;
            rsp_pc_nxt_s = rsp_pc_r + PC_STEP;
          end else begin
            rsp_pc_nxt_s = rsp_pc_r;
          end
        end
        FLUSH: begin
          if (outstanding_nxt_s == CW'(0)) begin
            state_nxt_s  = RUN;
            req_pc_nxt_s = flush_tgt_s;
            rsp_pc_nxt_s = flush_tgt_s;
          end else begin
            target_nxt_s = flush_tgt_s;
          end
        end
        ERROR: begin
          state_nxt_s = ERROR;
        end
        default: begin
          state_nxt_s = BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner
// sequences and a randomized run against a program-order scoreboard.
module tb_fetch_unit;
  import rv32i_pkg::*;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        inst_valid, inst_ready, redirect_valid, fetch_error;
  logic [31:0] inst_data, inst_pc, redirect_pc;

  logic        rv2, rspv2, iv2, fe2;
  logic [31:0] addr2, rspd2, data2, pc2;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_error(fetch_error)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clock(clock), .reset(reset),
    .imem_req_valid(rv2), .imem_req_ready(1'b1), .imem_req_addr(addr2),
    .imem_rsp_valid(rspv2), .imem_rsp_data(rspd2),
    .inst_valid(iv2), .inst_ready(1'b1), .inst_data(data2), .inst_pc(pc2),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000), .fetch_error(fe2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  int n_wrap = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic        pend2 = 1'b0;
  logic [31:0] pend_addr2 = 32'h0;
  logic [31:0] exp2 = 32'hFFFF_FFF8;

  logic        obs_rv, obs_iv, obs_fe;
  logic [31:0] obs_addr, obs_pc, obs_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs and memory response at negedge, sample outputs 1 time unit later.
  task automatic step(input logic rst, input logic rr, input logic ir, input logic rd, input logic [31:0] rpc);
    @(negedge clock);
    reset          = ~rst;
    imem_req_ready = rr;
    inst_ready     = ir;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    rspv2          = 1'b0;
    rspd2          = 32'h0;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (q_due.size() != 0 && q_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (pend2) begin
        rspv2 = 1'b1;
        rspd2 = mem_word(pend_addr2);
      end
    end
    #1;
    obs_rv = imem_req_valid; obs_addr = imem_req_addr; obs_iv = inst_valid;
    obs_pc = inst_pc; obs_data = inst_data; obs_fe = fetch_error;
    if (!rst && imem_req_valid && rr) begin
      q_addr.push_back(imem_req_addr);
      q_due.push_back(cyc + lat);
    end
    pend2      = !rst && rv2;
    pend_addr2 = addr2;
    if (rst) begin
      exp2 = 32'hFFFF_FFF8;
    end else if (iv2) begin
      chk("wrap_pc", pc2, exp2);
      chk("wrap_data", data2, mem_word(exp2));
      exp2 = exp2 + 32'd4;
      n_wrap++;
    end
    cyc++;
  endtask

  typedef struct {
    logic        rst;
    logic        ir;
    logic        ev;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] epc;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  logic        r_rr, r_ir, r_rd, p_iv, p_ir, p_rd, found;
  logic [31:0] r_rpc, p_pc, exp_req, exp_pc;
  int          pops;

  initial begin
    imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; rspv2 = 1'b0; rspd2 = 32'h0;

    // Streaming with ready=1, then a 5-cycle decoder stall, both from reset.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

    lat = 1;
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, 1'b1, vecs[i].ir, 1'b0, 32'h0);
      chk($sformatf("vec%0d_req_valid", i), 32'(obs_rv), 32'(vecs[i].ev));
      if (vecs[i].ev || vecs[i].rst) chk($sformatf("vec%0d_req_addr", i), obs_addr, vecs[i].ea);
      chk($sformatf("vec%0d_inst_valid", i), 32'(obs_iv), 32'(vecs[i].eiv));
      if (vecs[i].eiv || vecs[i].rst) begin
        chk($sformatf("vec%0d_inst_pc", i), obs_pc, vecs[i].epc);
        chk($sformatf("vec%0d_inst_data", i), obs_data, vecs[i].rst ? 32'h0 : mem_word(vecs[i].epc));
      end
      chk($sformatf("vec%0d_fetch_error", i), 32'(obs_fe), 32'd0);
    end

    // Redirect with two reads in flight at latency 3.
    lat = 3;
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_req0_addr", obs_addr, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_req1_addr", obs_addr, 32'h4);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    chk("t3_redirect_no_req", 32'(obs_rv), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_flush_state", 32'(dut.state_r), 32'(FLUSH));
    chk("t3_flush_iv_a", 32'(obs_iv), 32'd0);
    chk("t3_flush_rv_a", 32'(obs_rv), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_flush_iv_b", 32'(obs_iv), 32'd0);
    chk("t3_flush_rv_b", 32'(obs_rv), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_restart_rv", 32'(obs_rv), 32'd1);
    chk("t3_restart_addr", obs_addr, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      found = obs_iv;
    end
    chk("t3_inst_seen", 32'(found), 32'd1);
    chk("t3_first_pc", obs_pc, 32'h100);
    chk("t3_first_data", obs_data, mem_word(32'h100));

    // Misaligned redirect is sticky until reset.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h102);
    chk("t4_redirect_no_req", 32'(obs_rv), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("t4_fetch_error", 32'(obs_fe), 32'd1);
      chk("t4_no_req", 32'(obs_rv), 32'd0);
      chk("t4_no_inst", 32'(obs_iv), 32'd0);
    end

    // Asynchronous reset with a full buffer, then restart from RESET_PC.
    lat = 1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t6_full_iv", 32'(obs_iv), 32'd1);
    chk("t6_full_no_req", 32'(obs_rv), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t6_rst_rv", 32'(obs_rv), 32'd0);
    chk("t6_rst_addr", obs_addr, 32'h0);
    chk("t6_rst_iv", 32'(obs_iv), 32'd0);
    chk("t6_rst_pc", obs_pc, 32'h0);
    chk("t6_rst_data", obs_data, 32'h0);
    chk("t6_rst_fe", 32'(obs_fe), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_restart_rv", 32'(obs_rv), 32'd1);
    chk("t6_restart_addr", obs_addr, 32'h0);

    // Randomized traffic against a program-order scoreboard.
    for (int b = 0; b < 4; b++) begin
      lat = $urandom_range(1, 3);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      exp_req = 32'h0; exp_pc = 32'h0;
      p_iv = 1'b0; p_ir = 1'b0; p_rd = 1'b0; p_pc = 32'h0; pops = 0;
      for (int k = 0; k < 400; k++) begin
        r_rr  = ($urandom_range(0, 3) != 0);
        r_ir  = ($urandom_range(0, 9) < 7);
        r_rd  = ($urandom_range(0, 31) == 0);
        r_rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
        step(1'b0, r_rr, r_ir, r_rd, r_rpc);
        if (p_rd) begin
          chk("rnd_post_redirect_iv", 32'(obs_iv), 32'd0);
        end else if (p_iv && !p_ir) begin
          chk("rnd_hold_iv", 32'(obs_iv), 32'd1);
          chk("rnd_hold_pc", obs_pc, p_pc);
        end
        if (r_rd) chk("rnd_redirect_no_req", 32'(obs_rv), 32'd0);
        if (obs_rv && r_rr) begin
          chk("rnd_req_addr", obs_addr, exp_req);
          exp_req = exp_req + 32'd4;
        end
        if (obs_iv && r_ir) begin
          chk("rnd_inst_pc", obs_pc, exp_pc);
          chk("rnd_inst_data", obs_data, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
        if (r_rd) begin
          exp_req = r_rpc;
          exp_pc  = r_rpc;
        end
        chk("rnd_inflight_bound", 32'(q_due.size() <= DEPTH), 32'd1);
        chk("rnd_no_error", 32'(obs_fe), 32'd0);
        p_iv = obs_iv; p_ir = r_ir; p_rd = r_rd; p_pc = obs_pc;
      end
      chk("rnd_progress", 32'(pops > 20), 32'd1);
    end

    chk("wrap_seen", 32'(n_wrap >= 3), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
